// File: rtl/fp_addsub_seq.sv
// fp_addsub_seq: multi-cycle parametrised FP add/subtract with valid/ready.
// Define FP_ROUND_NEAREST_EN for round-to-nearest-even; default truncates.
module fp_addsub_seq #(
  parameter int EXP_W = 5,
  parameter int MAN_W = 10,
  localparam int W = 1 + EXP_W + MAN_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         op,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] result,
  output logic         ovf,
  output logic         unf,
  output logic         nan,
  output logic         zero
);
  localparam int MW = MAN_W + 4;
  localparam int XW = EXP_W + $clog2(MW + 1) + 1;
  localparam logic [XW-1:0] EMAX = XW'((1 << EXP_W) - 1);
  localparam logic [W-1:0] QNAN =
    {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

  typedef enum logic [2:0] {
    S_IDLE, S_ALIGN, S_ADD, S_NORM, S_ROUND, S_DONE
  } state_t;

  state_t        state_q;
  logic [W-1:0]  a_q, b_q, sres_q, result_q;
  logic          op_q, spec_q, snan_q, sign_q, sub_q;
  logic [XW-1:0] exp_q;
  logic [MW-1:0] ml_q, ms_q, mant_q;
  logic [MW:0]   sum_q;
  logic          flush_q, nunf_q;
  logic          out_valid_q, ovf_q, unf_q, nan_q, zero_q;

  function automatic logic [XW-1:0] lzc(input logic [MW-1:0] v);
    lzc = XW'(MW);
    for (int i = 0; i < MW; i++)
      if (v[i]) lzc = XW'(MW - 1 - i);
  endfunction

  logic [EXP_W-1:0] ea, eb, el, es, dd;
  logic [MAN_W-1:0] fa, fb;
  logic             sa, sb, a_ge;
  logic             a_inf, b_inf, a_nan, b_nan;
  logic [MW-1:0]    xa, xb, xl, xs, ms_d;
  logic [2*MW-1:0]  wide;
  logic             spec_d, snan_d;
  logic [W-1:0]     sres_d;

  always_comb begin
    ea = a_q[W-2:MAN_W];
    eb = b_q[W-2:MAN_W];
    fa = (ea == '0) ? '0 : a_q[MAN_W-1:0];
    fb = (eb == '0) ? '0 : b_q[MAN_W-1:0];
    sa = a_q[W-1];
    sb = b_q[W-1] ^ op_q;
    a_inf = &ea;
    b_inf = &eb;
    a_nan = a_inf && (a_q[MAN_W-1:0] != '0);
    b_nan = b_inf && (b_q[MAN_W-1:0] != '0);
    spec_d = a_inf | b_inf;
    snan_d = a_nan | b_nan | (a_inf & b_inf & (sa ^ sb));
    sres_d = snan_d ? QNAN :
      {a_inf ? sa : sb, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    a_ge = {ea, fa} >= {eb, fb};
    xa = {ea != '0, fa, 3'b000};
    xb = {eb != '0, fb, 3'b000};
    el = a_ge ? ea : eb;
    es = a_ge ? eb : ea;
    xl = a_ge ? xa : xb;
    xs = a_ge ? xb : xa;
    dd = el - es;
    wide = {xs, {MW{1'b0}}} >> dd;
    // bits shifted past the round position collapse into sticky
    if (int'(dd) >= MW)
      ms_d = {{(MW-1){1'b0}}, |xs};
    else
      ms_d = {wide[2*MW-1:MW+1], wide[MW] | (|wide[MW-1:0])};
  end

  logic [MW:0] sum_d;
  logic        sgn_add_d;

  always_comb begin
    if (sub_q) sum_d = {1'b0, ml_q} - {1'b0, ms_q};
    else       sum_d = {1'b0, ml_q} + {1'b0, ms_q};
    sgn_add_d = (sub_q && sum_d == '0) ? 1'b0 : sign_q;
  end

  logic [XW-1:0] z, exp_n_d;
  logic [MW-1:0] mant_d;
  logic          flush_d, nunf_d;

  always_comb begin
    z = lzc(sum_q[MW-1:0]);
    mant_d = sum_q[MW-1:0] << z;
    exp_n_d = exp_q - z;
    flush_d = 1'b0;
    nunf_d = 1'b0;
    if (sum_q[MW]) begin
      mant_d = {sum_q[MW:2], |sum_q[1:0]};
      exp_n_d = exp_q + 1'b1;
    end else if (sum_q == '0) begin
      flush_d = 1'b1;
    end else if (exp_q <= z) begin
      flush_d = 1'b1;
      nunf_d = 1'b1;
    end
  end

  logic             inc;
  logic [MAN_W+1:0] rnd;
  logic [XW-1:0]    exp_r;
  logic [MAN_W-1:0] frac_r;
  logic [W-1:0]     res_d;
  logic             ovf_d;

`ifdef FP_ROUND_NEAREST_EN
  assign inc = mant_q[2] & (mant_q[1] | mant_q[0] | mant_q[3]);
`else
  logic unused_grs;
  assign inc = 1'b0;
  assign unused_grs = ^mant_q[2:0];
`endif

  always_comb begin
    rnd = {1'b0, mant_q[MW-1:3]} + {{(MAN_W+1){1'b0}}, inc};
    exp_r = exp_q;
    frac_r = rnd[MAN_W-1:0];
    if (rnd[MAN_W+1]) begin
      exp_r = exp_q + 1'b1;
      frac_r = rnd[MAN_W:1];
    end
    ovf_d = !spec_q && !flush_q && (exp_r >= EMAX);
    if (spec_q)
      res_d = sres_q;
    else if (flush_q)
      res_d = {sign_q, {(W-1){1'b0}}};
    else if (ovf_d)
      res_d = {sign_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    else
      res_d = {sign_q, exp_r[EXP_W-1:0], frac_r};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      ovf_q       <= 1'b0;
      unf_q       <= 1'b0;
      nan_q       <= 1'b0;
      zero_q      <= 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: if (in_valid) begin
          a_q     <= a;
          b_q     <= b;
          op_q    <= op;
          state_q <= S_ALIGN;
        end
        S_ALIGN: begin
          spec_q  <= spec_d;
          snan_q  <= snan_d;
          sres_q  <= sres_d;
          sign_q  <= a_ge ? sa : sb;
          sub_q   <= sa ^ sb;
          exp_q   <= XW'(el);
          ml_q    <= xl;
          ms_q    <= ms_d;
          state_q <= S_ADD;
        end
        S_ADD: begin
          sum_q   <= sum_d;
          sign_q  <= sgn_add_d;
          state_q <= S_NORM;
        end
        S_NORM: begin
          mant_q  <= mant_d;
          exp_q   <= exp_n_d;
          flush_q <= flush_d;
          nunf_q  <= nunf_d;
          state_q <= S_ROUND;
        end
        S_ROUND: begin
          result_q <= res_d;
          ovf_q    <= ovf_d;
          unf_q    <= !spec_q & nunf_q;
          nan_q    <= spec_q & snan_q;
          zero_q   <= res_d[W-2:MAN_W] == '0;
          state_q  <= S_DONE;
        end
        S_DONE: begin
          if (!out_valid_q) begin
            out_valid_q <= 1'b1;
          end else if (out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign in_ready  = !rst && (state_q == S_IDLE);
  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign ovf       = ovf_q;
  assign unf       = unf_q;
  assign nan       = nan_q;
  assign zero      = zero_q;

endmodule

// File: tb/tb_fp_addsub_seq.sv
// tb_fp_addsub_seq: directed and randomised checks of fp_addsub_seq
// against an exact-arithmetic half-precision reference model.
module tb_fp_addsub_seq;
  localparam int EXP_W = 5;
  localparam int MAN_W = 10;
  localparam int W = 1 + EXP_W + MAN_W;

  logic         clk = 1'b0;
  logic         rst, in_valid, in_ready, op;
  logic         out_valid, out_ready;
  logic         ovf, unf, nan, zero;
  logic [W-1:0] a, b, result;
  int n_checks = 0;
  int n_fail = 0;

  fp_addsub_seq #(.EXP_W(EXP_W), .MAN_W(MAN_W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .op(op),
    .out_valid(out_valid), .out_ready(out_ready),
    .result(result),
    .ovf(ovf), .unf(unf), .nan(nan), .zero(zero)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

`ifdef FP_ROUND_NEAREST_EN
  localparam logic [15:0] RND_EXP = 16'h3C02;
`else
  localparam logic [15:0] RND_EXP = 16'h3C01;
`endif

  typedef struct packed {
    logic [15:0] a;
    logic [15:0] b;
    logic        op;
    logic [15:0] r;
    logic [3:0]  f;
  } vec_t;

  localparam int NV = 11;
  localparam vec_t VECS [NV] = '{
    '{16'h3C00, 16'h3C00, 1'b0, 16'h4000, 4'b0000},
    '{16'h4000, 16'h3C00, 1'b1, 16'h3C00, 4'b0000},
    '{16'h3C00, 16'h3C00, 1'b1, 16'h0000, 4'b0001},
    '{16'h3C01, 16'h1000, 1'b0, RND_EXP,  4'b0000},
    '{16'h7BFF, 16'h7BFF, 1'b0, 16'h7C00, 4'b1000},
    '{16'h7C00, 16'h7C00, 1'b1, 16'h7E00, 4'b0010},
    '{16'h7C00, 16'h3C00, 1'b0, 16'h7C00, 4'b0000},
    '{16'h0401, 16'h0400, 1'b1, 16'h0000, 4'b0101},
    '{16'hBC00, 16'h3800, 1'b0, 16'hB800, 4'b0000},
    '{16'h7E01, 16'h3C00, 1'b0, 16'h7E00, 4'b0010},
    '{16'h3C00, 16'h7C00, 1'b1, 16'hFC00, 4'b0000}
  };

  // flags packed as {ovf, unf, nan, zero}
  function automatic void model(
    input  logic [15:0] xa, xb,
    input  logic        xop,
    output logic [15:0] r,
    output logic [3:0]  f
  );
    int ea, eb, p, e;
    logic sa, sb, sr, an, bn;
    longint va, vb, x;
    logic [63:0] mag, mant;
    ea = int'(xa[14:10]);
    eb = int'(xb[14:10]);
    sa = xa[15];
    sb = xb[15] ^ xop;
    f = 4'b0000;
    if (ea == 31 || eb == 31) begin
      an = (ea == 31) && (xa[9:0] != 10'd0);
      bn = (eb == 31) && (xb[9:0] != 10'd0);
      if (an || bn || (ea == 31 && eb == 31 && sa != sb)) begin
        r = 16'h7E00;
        f = 4'b0010;
      end else begin
        r = {(ea == 31) ? sa : sb, 15'h7C00};
      end
      return;
    end
    va = (ea == 0) ? 0 : (longint'({1'b1, xa[9:0]}) << (ea - 1));
    vb = (eb == 0) ? 0 : (longint'({1'b1, xb[9:0]}) << (eb - 1));
    x = (sa ? -va : va) + (sb ? -vb : vb);
    if (x == 0) begin
      r = {(sa == sb) ? sa : 1'b0, 15'h0};
      f = 4'b0001;
      return;
    end
    sr = x < 0;
    mag = sr ? 64'(-x) : 64'(x);
    p = 0;
    for (int i = 0; i < 64; i++)
      if (mag[i]) p = i;
    if (p < 10) begin
      r = {sr, 15'h0};
      f = 4'b0101;
      return;
    end
    e = p - 9;
    mant = mag >> (e - 1);
`ifdef FP_ROUND_NEAREST_EN
    if (e > 1) begin
      logic [63:0] rem, half;
      rem = mag - (mant << (e - 1));
      half = 64'd1 << (e - 2);
      if (rem > half || (rem == half && mant[0]))
        mant = mant + 64'd1;
    end
`endif
    if (mant == 64'd2048) begin
      mant = 64'd1024;
      e = e + 1;
    end
    if (e >= 31) begin
      r = {sr, 15'h7C00};
      f = 4'b1000;
    end else begin
      r = {sr, 5'(e), mant[9:0]};
    end
  endfunction

  function automatic logic [15:0] rand_operand();
    logic [15:0] v;
    int k;
    v = 16'($urandom);
    k = $urandom_range(0, 19);
    if (k == 0) v[14:10] = 5'd0;
    else if (k == 1) v[14:10] = 5'h1F;
    else if (k == 2) v[14:10] = 5'h1E;
    else if (k == 3) v[14:0] = 15'h7C00;
    return v;
  endfunction

  task automatic run_op(
    input  logic [15:0] xa, xb,
    input  logic        xop,
    input  logic        hold,
    output logic [15:0] r,
    output logic [3:0]  f,
    output int          lat
  );
    int guard;
    guard = 0;
    while (!in_ready && guard < 20) begin
      @(posedge clk); #1;
      guard++;
    end
    a = xa;
    b = xb;
    op = xop;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    a = 16'($urandom);
    b = 16'($urandom);
    op = 1'($urandom);
    lat = 0;
    while (lat < 20) begin
      @(posedge clk); #1;
      lat++;
      if (out_valid) break;
    end
    r = result;
    f = {ovf, unf, nan, zero};
    n_checks++;
    if (out_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL op_timeout: out_valid=%b required 1", out_valid);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    if (!hold) out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    a = '0;
    b = '0;
    op = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_in_ready: got %b required 0", in_ready);
    end
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_out_valid: got %b required 0", out_valid);
    end
    n_checks++;
    if ({result, ovf, unf, nan, zero} !== 20'h0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %h/%b required 0000/0000",
               result, {ovf, unf, nan, zero});
    end
    rst = 1'b0;
    @(posedge clk); #1;
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_release_in_ready: got %b required 1", in_ready);
    end
  endtask

  task automatic test_directed();
    logic [15:0] r;
    logic [3:0] f;
    int lat;
    for (int i = 0; i < NV; i++) begin
      run_op(VECS[i].a, VECS[i].b, VECS[i].op, 1'b0, r, f, lat);
      n_checks++;
      if (r !== VECS[i].r) begin
        n_fail++;
        $display("FAIL directed[%0d] result: got %h required %h",
                 i, r, VECS[i].r);
      end
      n_checks++;
      if (f !== VECS[i].f) begin
        n_fail++;
        $display("FAIL directed[%0d] flags: got %b required %b",
                 i, f, VECS[i].f);
      end
      n_checks++;
      if (lat !== 5) begin
        n_fail++;
        $display("FAIL directed[%0d] latency: got %0d required 5", i, lat);
      end
    end
  endtask

  task automatic test_random();
    logic [15:0] xa, xb, r, mr;
    logic [3:0] f, mf;
    logic xop;
    int lat;
    for (int i = 0; i < 300; i++) begin
      xa = rand_operand();
      xb = rand_operand();
      xop = 1'($urandom);
      if ($urandom_range(0, 3) == 0) xb[14:10] = xa[14:10];
      if ($urandom_range(0, 15) == 0) xb[14:0] = xa[14:0];
      model(xa, xb, xop, mr, mf);
      run_op(xa, xb, xop, 1'b0, r, f, lat);
      n_checks++;
      if (r !== mr || f !== mf) begin
        n_fail++;
        $display("FAIL random %h %s %h: got %h/%b required %h/%b",
                 xa, xop ? "-" : "+", xb, r, f, mr, mf);
      end
    end
  endtask

  task automatic test_backpressure();
    int guard;
    logic [15:0] r;
    logic [3:0] f;
    int lat;
    a = 16'h4000;
    b = 16'h3C00;
    op = 1'b0;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    guard = 0;
    while (!out_valid && guard < 20) begin
      @(posedge clk); #1;
      guard++;
    end
    a = 16'h3C00;
    b = 16'h3C00;
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      n_checks++;
      if (result !== 16'h4200 || out_valid !== 1'b1) begin
        n_fail++;
        $display("FAIL hold[%0d]: got %h valid %b required 4200 valid 1",
                 i, result, out_valid);
      end
      n_checks++;
      if (in_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL hold_in_ready[%0d]: got %b required 0", i, in_ready);
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL release: valid %b ready %b required 0 1",
               out_valid, in_ready);
    end
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      n_checks++;
      if (out_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL no_queue[%0d]: out_valid %b required 0", i, out_valid);
      end
    end
    run_op(16'h3C00, 16'hC000, 1'b0, 1'b0, r, f, lat);
    n_checks++;
    if (r !== 16'hBC00 || f !== 4'b0000) begin
      n_fail++;
      $display("FAIL after_hold: got %h/%b required bc00/0000", r, f);
    end
  endtask

  task automatic test_reset_mid();
    logic [15:0] r;
    logic [3:0] f;
    int lat;
    a = 16'h7BFF;
    b = 16'h7BFF;
    op = 1'b0;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_reset: valid %b ready %b required 0 0",
               out_valid, in_ready);
    end
    rst = 1'b0;
    #1;
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_reset_ready: got %b required 1", in_ready);
    end
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      n_checks++;
      if (out_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL discarded[%0d]: out_valid %b required 0",
                 i, out_valid);
      end
    end
    run_op(16'h3C00, 16'h3800, 1'b0, 1'b0, r, f, lat);
    n_checks++;
    if (r !== 16'h3E00 || f !== 4'b0000) begin
      n_fail++;
      $display("FAIL after_reset: got %h/%b required 3e00/0000", r, f);
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] xa, xb, r, mr;
    logic [3:0] f, mf;
    logic xop;
    int lat;
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      xa = rand_operand();
      xb = rand_operand();
      xop = 1'($urandom);
      model(xa, xb, xop, mr, mf);
      run_op(xa, xb, xop, 1'b1, r, f, lat);
      n_checks++;
      if (r !== mr || f !== mf || lat !== 5) begin
        n_fail++;
        $display("FAIL b2b %h %b %h: got %h/%b lat %0d required %h/%b lat 5",
                 xa, xop, xb, r, f, lat, mr, mf);
      end
    end
    out_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
